// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : link_pkg
// Description : Shared link definitions: word/byte geometry, state encoding,
//               and the per-byte parity used by transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package link_pkg;

    localparam int LINK_WORD_W    = 32;
    localparam int LINK_BYTE_W    = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2,
        ERROR    = 2'd3
    } linkState_e;

    // Even parity: the XOR of all bits, so byte plus parity has even weight.
    function automatic logic linkParity(input logic [LINK_BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : link_tx_serializer
// Description : Serializes 32-bit words MSB byte first onto an 8-bit link with
//               even parity, then waits for ACK/NACK with timeout and retries.
// Revision    : 1.0 - initial release
// ============================================================================
module link_tx_serializer
    import link_pkg::*;
#(
    parameter int MAX_RETRY   = 3,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   Clk_r,
    input  logic                   Rst,
    input  logic [LINK_WORD_W-1:0] TxData,
    input  logic                   TxData_Valid,
    output logic                   Tx_Ready,
    output logic                   Tx_Error,
    input  logic                   Error_Ack,
    output logic [LINK_BYTE_W-1:0] Link_Data,
    output logic                   Link_Valid,
    output logic                   Link_Parity,
    input  logic                   Link_Ack,
    input  logic                   Link_Nack
);

    // A zero-retry build still needs a one-bit counter to hold the value 0.
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    localparam logic [1:0] c_stIdle  = IDLE;
    localparam logic [1:0] c_stSend  = SEND;
    localparam logic [1:0] c_stWait  = WAIT_ACK;
    localparam logic [1:0] c_stError = ERROR;

    localparam logic [RTY_W-1:0] c_maxRetry   = RTY_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0] c_timeoutEnd = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] c_lastByte   = IDX_W'(BYTES_PER_WORD - 1);

    logic [1:0]             r_state;
    logic [IDX_W-1:0]       r_byteIdx;
    logic [RTY_W-1:0]       r_retry;
    logic [TMO_W-1:0]       r_timeout;
    logic [LINK_WORD_W-1:0] r_word;

    logic [1:0]             w_nextState;
    logic [IDX_W-1:0]       w_nextIdx;
    logic [RTY_W-1:0]       w_nextRetry;
    logic [TMO_W-1:0]       w_nextTimeout;
    logic [LINK_WORD_W-1:0] w_nextWord;
    logic                   w_attemptFailed;
    logic [LINK_WORD_W-1:0] w_shiftedWord;
    logic [LINK_BYTE_W-1:0] w_sendByte;
    logic                   w_nextSend;

    always_comb begin
        w_nextState     = r_state;
        w_nextIdx       = r_byteIdx;
        w_nextRetry     = r_retry;
        w_nextTimeout   = r_timeout;
        w_nextWord      = r_word;
        w_attemptFailed = 1'b0;

        case (r_state)
            c_stIdle: begin
                if (TxData_Valid && Tx_Ready) begin
                    w_nextWord  = TxData;
                    w_nextRetry = '0;
                    w_nextIdx   = '0;
                    w_nextState = c_stSend;
                end
            end
            c_stSend: begin
                if (r_byteIdx == c_lastByte) begin
                    w_nextTimeout = '0;
                    w_nextState   = c_stWait;
                end else begin
                    w_nextIdx = r_byteIdx + 1'b1;
                end
            end
            c_stWait: begin
                // Nack beats Ack; a clean Ack beats a coincident timeout.
                if (Link_Nack) begin
                    w_attemptFailed = 1'b1;
                end else if (Link_Ack) begin
                    w_nextState = c_stIdle;
                end else if (r_timeout == c_timeoutEnd) begin
                    w_attemptFailed = 1'b1;
                end else begin
                    w_nextTimeout = r_timeout + 1'b1;
                end

                if (w_attemptFailed) begin
                    if (r_retry < c_maxRetry) begin
                        w_nextRetry   = r_retry + 1'b1;
                        w_nextTimeout = '0;
                        w_nextIdx     = '0;
                        w_nextState   = c_stSend;
                    end else begin
                        w_nextState = c_stError;
                    end
                end
            end
            c_stError: begin
                if (Error_Ack) begin
                    w_nextWord  = '0;
                    w_nextState = c_stIdle;
                end
            end
            default: begin
                w_nextState = c_stIdle;
            end
        endcase
    end

    // Outputs are registered from next-state values so each byte appears in
    // the cycle right after the edge that selects it.
    assign w_nextSend    = (w_nextState == c_stSend);
    assign w_shiftedWord = w_nextWord << (int'(w_nextIdx) * LINK_BYTE_W);
    assign w_sendByte    = w_shiftedWord[LINK_WORD_W-1 -: LINK_BYTE_W];

    always_ff @(posedge Clk_r) begin
        if (Rst) begin
            r_state     <= c_stIdle;
            r_byteIdx   <= '0;
            r_retry     <= '0;
            r_timeout   <= '0;
            r_word      <= '0;
            Tx_Ready    <= 1'b0;
            Tx_Error    <= 1'b0;
            Link_Valid  <= 1'b0;
            Link_Data   <= '0;
            Link_Parity <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_byteIdx   <= w_nextIdx;
            r_retry     <= w_nextRetry;
            r_timeout   <= w_nextTimeout;
            r_word      <= w_nextWord;
            Tx_Ready    <= (w_nextState == c_stIdle);
            Tx_Error    <= (w_nextState == c_stError);
            Link_Valid  <= w_nextSend;
            Link_Data   <= w_nextSend ? w_sendByte : '0;
            Link_Parity <= w_nextSend ? linkParity(w_sendByte) : 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_link_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_tx_serializer
// Description : Self-checking bench: vector table of words/responses plus
//               hand sequences for timeout, ignored inputs and mid-word reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_tx_serializer;

    localparam int MAX_RETRY   = 3;
    localparam int ACK_TIMEOUT = 16;

    logic        Clk_r = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] TxData = '0;
    logic        TxData_Valid = 1'b0;
    logic        Tx_Ready;
    logic        Tx_Error;
    logic        Error_Ack = 1'b0;
    logic [7:0]  Link_Data;
    logic        Link_Valid;
    logic        Link_Parity;
    logic        Link_Ack = 1'b0;
    logic        Link_Nack = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } beat_t;

    typedef struct {
        logic [31:0] word;
        int          nacks;
        bit          ackWithNack;
    } vec_t;

    beat_t sbQ[$];
    vec_t  vecs[6];

    link_tx_serializer #(
        .MAX_RETRY   (MAX_RETRY),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .Clk_r        (Clk_r),
        .Rst          (Rst),
        .TxData       (TxData),
        .TxData_Valid (TxData_Valid),
        .Tx_Ready     (Tx_Ready),
        .Tx_Error     (Tx_Error),
        .Error_Ack    (Error_Ack),
        .Link_Data    (Link_Data),
        .Link_Valid   (Link_Valid),
        .Link_Parity  (Link_Parity),
        .Link_Ack     (Link_Ack),
        .Link_Nack    (Link_Nack)
    );

    always #5 Clk_r = ~Clk_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk_r);
        #1;
    endtask

    task automatic pushBurst(input logic [31:0] w);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.data = w[31 - 8*i -: 8];
            b.par  = ^b.data;
            sbQ.push_back(b);
        end
    endtask

    // Every valid link beat must match the oldest expected beat.
    always @(negedge Clk_r) begin
        if (Link_Valid === 1'b1) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %02h expected none at %0t", Link_Data, $time);
            end else begin
                beat_t e;
                e = sbQ.pop_front();
                check("link_data", 32'(Link_Data), 32'(e.data));
                check("link_parity", 32'(Link_Parity), 32'(e.par));
            end
        end
    end

    task automatic capture(input logic [31:0] w);
        int n;
        n = 0;
        while (Tx_Ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_capture", 32'(Tx_Ready), 32'd1);
        pushBurst(w);
        TxData       = w;
        TxData_Valid = 1'b1;
        tick();
        TxData_Valid = 1'b0;
        TxData       = $urandom();
        check("ready_low_after_capture", 32'(Tx_Ready), 32'd0);
        check("valid_after_capture", 32'(Link_Valid), 32'd1);
    endtask

    task automatic errorPhase();
        check("error_rises", 32'(Tx_Error), 32'd1);
        check("ready_low_in_error", 32'(Tx_Ready), 32'd0);
        for (int i = 1; i < 10; i++) begin
            tick();
            check("error_held", 32'(Tx_Error), 32'd1);
        end
        Error_Ack = 1'b1;
        tick();
        Error_Ack = 1'b0;
        check("error_cleared", 32'(Tx_Error), 32'd0);
        check("ready_after_error_ack", 32'(Tx_Ready), 32'd1);
    endtask

    task automatic runVec(input vec_t v);
        capture(v.word);
        repeat (4) tick();
        check("wait_ack_link_idle", 32'(Link_Valid), 32'd0);
        for (int a = 0; a <= v.nacks; a++) begin
            if (a < v.nacks) begin
                Link_Nack = 1'b1;
                Link_Ack  = v.ackWithNack;
                if (a < MAX_RETRY) pushBurst(v.word);
                tick();
                Link_Nack = 1'b0;
                Link_Ack  = 1'b0;
                if (a < MAX_RETRY) begin
                    check("retransmit_start", 32'(Link_Valid), 32'd1);
                    check("no_error_on_retry", 32'(Tx_Error), 32'd0);
                    repeat (4) tick();
                end else begin
                    errorPhase();
                    break;
                end
            end else begin
                Link_Ack = 1'b1;
                tick();
                Link_Ack = 1'b0;
                check("ready_after_ack", 32'(Tx_Ready), 32'd1);
                check("no_error_after_ack", 32'(Tx_Error), 32'd0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'hA1B2C3D4, 0, 1'b0};
        vecs[1] = '{32'h00000005, 1, 1'b0};
        vecs[2] = '{32'hDEADBEEF, MAX_RETRY + 1, 1'b0};
        vecs[3] = '{32'h12345678, 2, 1'b1};
        vecs[4] = '{32'h00000000, 0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, MAX_RETRY, 1'b0};

        // Reset values, then a valid offered before Tx_Ready must be dropped.
        repeat (3) tick();
        check("rst_ready", 32'(Tx_Ready), 32'd0);
        check("rst_error", 32'(Tx_Error), 32'd0);
        check("rst_valid", 32'(Link_Valid), 32'd0);
        check("rst_data", 32'(Link_Data), 32'd0);
        check("rst_parity", 32'(Link_Parity), 32'd0);
        Rst          = 1'b0;
        TxData       = 32'hCAFEF00D;
        TxData_Valid = 1'b1;
        tick();
        TxData_Valid = 1'b0;
        check("ready_after_rst", 32'(Tx_Ready), 32'd1);
        check("early_valid_ignored", 32'(Link_Valid), 32'd0);
        tick();
        check("early_valid_not_queued", 32'(Link_Valid), 32'd0);

        for (int i = 0; i < 6; i++) begin
            runVec(vecs[i]);
        end

        // Ack and Error_Ack during SEND are ignored; no response -> timeout retry.
        capture(32'h13579BDF);
        Link_Ack  = 1'b1;
        Error_Ack = 1'b1;
        tick();
        Link_Ack  = 1'b0;
        Error_Ack = 1'b0;
        repeat (3) tick();
        check("ack_in_send_ignored", 32'(Tx_Ready), 32'd0);
        check("wait_entered", 32'(Link_Valid), 32'd0);
        pushBurst(32'h13579BDF);
        for (int i = 1; i < ACK_TIMEOUT; i++) begin
            tick();
            check("timeout_quiet", 32'(Link_Valid), 32'd0);
        end
        tick();
        check("timeout_retransmit", 32'(Link_Valid), 32'd1);
        repeat (4) tick();
        Link_Ack = 1'b1;
        tick();
        Link_Ack = 1'b0;
        check("ready_after_timeout_ack", 32'(Tx_Ready), 32'd1);

        // Reset while byte 2 is on the link.
        capture(32'hFFFFFF1F);
        repeat (2) tick();
        Rst = 1'b1;
        tick();
        check("midrst_valid", 32'(Link_Valid), 32'd0);
        check("midrst_ready", 32'(Tx_Ready), 32'd0);
        check("midrst_error", 32'(Tx_Error), 32'd0);
        check("midrst_undelivered", 32'(sbQ.size()), 32'd1);
        sbQ.delete();
        Rst = 1'b0;
        tick();
        check("ready_after_midrst", 32'(Tx_Ready), 32'd1);
        check("no_partial_byte", 32'(Link_Valid), 32'd0);
        runVec('{32'h0F0F0F0F, 0, 1'b0});

        repeat (2) tick();
        check("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
